// File: rtl/pagerank_pkg.sv
// -----------------------------------------------------------------------------
// pagerank_pkg
// Shared types and helpers for the pagerank apply stage.
//   rank_t        : unsigned Q32.32 fixed-point value (64 bits)
//   FRAC_BITS     : number of fractional bits in rank_t
//   apply_state_t : control states of pagerank_apply
//   sat_add64     : 64-bit unsigned add that clamps at 2^64-1 instead of wrapping
// -----------------------------------------------------------------------------
package pagerank_pkg;

  typedef logic [63:0] rank_t;

  localparam int unsigned FRAC_BITS = 32;
  localparam rank_t       RANK_MAX  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } apply_state_t;

  // The carry out of a 65-bit sum selects the clamp value.
  function automatic rank_t sat_add64(input rank_t a, input rank_t b);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[64] ? RANK_MAX : sum[63:0];
  endfunction

endpackage

// File: rtl/pagerank_apply_if.sv
// -----------------------------------------------------------------------------
// pagerank_apply_if
// Bundle between the thread serializer (master) and pagerank_apply (slave).
//   pagerank_serial_stream : NODES x Q32.32 partial sums of one packet
//   in_valid               : payload valid this cycle
//   stream_start           : all threads synced, iteration begins (level)
//   stream_done            : all packets sent (pulse)
//   ack                    : packet consumed (one-cycle pulse)
//   rank_out / rank_valid  : ranks of the last completed iteration
//   next_iteration         : request for another pass (pulse)
//   converged / finished   : convergence and termination status
//   iter_count             : completed iterations
//   pkt_error              : sticky packet-count error
// -----------------------------------------------------------------------------
interface pagerank_apply_if #(
  parameter int unsigned NODES = 32
);
  import pagerank_pkg::*;

  rank_t [NODES-1:0] pagerank_serial_stream;
  logic              in_valid;
  logic              stream_start;
  logic              stream_done;
  logic              ack;
  rank_t [NODES-1:0] rank_out;
  logic              rank_valid;
  logic              next_iteration;
  logic              converged;
  logic              finished;
  logic [31:0]       iter_count;
  logic              pkt_error;

  modport master (
    output pagerank_serial_stream, in_valid, stream_start, stream_done,
    input  ack, rank_out, rank_valid, next_iteration, converged, finished,
           iter_count, pkt_error
  );

  modport slave (
    input  pagerank_serial_stream, in_valid, stream_start, stream_done,
    output ack, rank_out, rank_valid, next_iteration, converged, finished,
           iter_count, pkt_error
  );

endinterface

// File: rtl/pagerank_damp_unit.sv
// -----------------------------------------------------------------------------
// pagerank_damp_unit
// Combinational damping for a single node:
//   rank_o  = sat(base_i + ((acc_i * damping_i) >> FRAC_BITS))
//   delta_o = |rank_o - prev_i|
// Ports:
//   acc_i     : accumulated partial sum, Q32.32
//   prev_i    : rank of this node from the previous iteration, Q32.32
//   damping_i : damping factor, Q0.32
//   base_i    : (1-d)/N, Q32.32
//   rank_o    : new rank, Q32.32
//   delta_o   : absolute change against prev_i
// -----------------------------------------------------------------------------
module pagerank_damp_unit
  import pagerank_pkg::*;
(
  input  rank_t       acc_i,
  input  rank_t       prev_i,
  input  logic [31:0] damping_i,
  input  rank_t       base_i,
  output rank_t       rank_o,
  output rank_t       delta_o
);

  rank_t prod_hi_s;

  // Q32.32 * Q0.32 is Q32.64 in 96 bits; dropping FRAC_BITS realigns to Q32.32.
  assign prod_hi_s = 64'(({32'd0, acc_i} * {64'd0, damping_i}) >> FRAC_BITS);

  assign rank_o  = sat_add64(base_i, prod_hi_s);
  assign delta_o = (rank_o >= prev_i) ? (rank_o - prev_i) : (prev_i - rank_o);

endmodule

// File: rtl/pagerank_apply.sv
// -----------------------------------------------------------------------------
// pagerank_apply
// Collects NUM_HW_THREADS packets of partial pagerank sums per iteration,
// sums them per node (saturating), then walks the nodes one per cycle through
// a single damping unit to produce rank = BASE_Q + d*sum. Tracks the largest
// per-node change to decide convergence and requests another pass otherwise.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : pagerank_apply_if slave (stream in, ranks and status out)
// -----------------------------------------------------------------------------
module pagerank_apply
  import pagerank_pkg::*;
#(
  parameter int unsigned NUM_HW_THREADS = 8,
  parameter int unsigned NODES_IN_GRAPH = 32,
  parameter logic [31:0] DAMPING_Q      = 32'd3650722202,
  parameter rank_t       EPS_Q          = 64'd4295,
  parameter int unsigned MAX_ITER       = 64
) (
  input  logic            clock,
  input  logic            reset_n,
  pagerank_apply_if.slave bus
);

  localparam int unsigned   JW     = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(NODES_IN_GRAPH - 1);
  localparam rank_t         BASE_Q = (64'd4294967296 - {32'd0, DAMPING_Q}) / 64'(NODES_IN_GRAPH);

  apply_state_t               state_q, state_d;
  logic [JW-1:0]              j_q, j_d;
  logic [31:0]                pkt_cnt_q, pkt_cnt_d;
  rank_t                      max_delta_q, max_delta_d;
  logic                       ack_q, ack_d;
  logic                       rank_valid_q, rank_valid_d;
  logic                       next_q, next_d;
  logic                       conv_q, conv_d;
  logic                       fin_q, fin_d;
  logic [31:0]                iter_q, iter_d;
  logic                       err_q, err_d;

  rank_t                      acc_q  [NODES_IN_GRAPH];
  rank_t                      prev_q [NODES_IN_GRAPH];
  rank_t [NODES_IN_GRAPH-1:0] rank_q;

  logic                       clear_acc_s;
  logic                       accum_s;
  logic                       write_rank_s;
  logic [31:0]                cnt_inc_s;
  logic [31:0]                iter_inc_s;
  rank_t                      new_rank_s;
  rank_t                      delta_s;
  rank_t                      max_upd_s;

  pagerank_damp_unit u_damp (
    .acc_i     (acc_q[j_q]),
    .prev_i    (prev_q[j_q]),
    .damping_i (DAMPING_Q),
    .base_i    (BASE_Q),
    .rank_o    (new_rank_s),
    .delta_o   (delta_s)
  );

  // Packet count including a packet arriving this cycle, so a packet that
  // coincides with stream_done is counted before the error check.
  assign cnt_inc_s  = pkt_cnt_q + {31'd0, bus.in_valid};
  assign iter_inc_s = iter_q + 32'd1;
  assign max_upd_s  = (delta_s > max_delta_q) ? delta_s : max_delta_q;

  // Next-state and control decode.
  always_comb begin
    state_d      = state_q;
    j_d          = j_q;
    pkt_cnt_d    = pkt_cnt_q;
    max_delta_d  = max_delta_q;
    ack_d        = 1'b0;
    rank_valid_d = rank_valid_q;
    next_d       = 1'b0;
    conv_d       = conv_q;
    fin_d        = fin_q;
    iter_d       = iter_q;
    err_d        = err_q;
    clear_acc_s  = 1'b0;
    accum_s      = 1'b0;
    write_rank_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.stream_start && !fin_q) begin
          state_d     = ACCUM;
          clear_acc_s = 1'b1;
          pkt_cnt_d   = 32'd0;
          max_delta_d = 64'd0;
          j_d         = {JW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end

      ACCUM: begin
        accum_s   = bus.in_valid;
        ack_d     = bus.in_valid;
        pkt_cnt_d = cnt_inc_s;
        if (bus.stream_done) begin
          state_d      = APPLY;
          j_d          = {JW{1'b0}};
          rank_valid_d = 1'b0;
          if (cnt_inc_s != 32'(NUM_HW_THREADS)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = ACCUM;
        end
      end

      APPLY: begin
        write_rank_s = 1'b1;
        max_delta_d  = max_upd_s;
        if (j_q == J_LAST) begin
          // Outputs for the DONE cycle use the max including the last node.
          state_d      = DONE;
          iter_d       = iter_inc_s;
          rank_valid_d = 1'b1;
          conv_d       = (max_upd_s <= EPS_Q);
          if ((max_upd_s <= EPS_Q) || (iter_inc_s == 32'(MAX_ITER))) begin
            fin_d = 1'b1;
          end else begin
            next_d = 1'b1;
          end
        end else begin
          j_d = j_q + {{(JW-1){1'b0}}, 1'b1};
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      j_q          <= {JW{1'b0}};
      pkt_cnt_q    <= 32'd0;
      max_delta_q  <= 64'd0;
      ack_q        <= 1'b0;
      rank_valid_q <= 1'b0;
      next_q       <= 1'b0;
      conv_q       <= 1'b0;
      fin_q        <= 1'b0;
      iter_q       <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      j_q          <= j_d;
      pkt_cnt_q    <= pkt_cnt_d;
      max_delta_q  <= max_delta_d;
      ack_q        <= ack_d;
      rank_valid_q <= rank_valid_d;
      next_q       <= next_d;
      conv_q       <= conv_d;
      fin_q        <= fin_d;
      iter_q       <= iter_d;
      err_q        <= err_d;
    end
  end

  // Per-node saturating accumulators.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NODES_IN_GRAPH; i++) acc_q[i] <= 64'd0;
    end else if (clear_acc_s) begin
      for (int i = 0; i < NODES_IN_GRAPH; i++) acc_q[i] <= 64'd0;
    end else if (accum_s) begin
      for (int i = 0; i < NODES_IN_GRAPH; i++) begin
        acc_q[i] <= sat_add64(acc_q[i], bus.pagerank_serial_stream[i]);
      end
    end
  end

  // Rank output and previous-iteration storage, written one node per APPLY cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rank_q <= {NODES_IN_GRAPH{64'd0}};
      for (int i = 0; i < NODES_IN_GRAPH; i++) prev_q[i] <= 64'd0;
    end else if (write_rank_s) begin
      rank_q[j_q] <= new_rank_s;
      prev_q[j_q] <= new_rank_s;
    end
  end

  assign bus.ack            = ack_q;
  assign bus.rank_out       = rank_q;
  assign bus.rank_valid     = rank_valid_q;
  assign bus.next_iteration = next_q;
  assign bus.converged      = conv_q;
  assign bus.finished       = fin_q;
  assign bus.iter_count     = iter_q;
  assign bus.pkt_error      = err_q;

endmodule

// File: tb/tb_pagerank_apply.sv
// -----------------------------------------------------------------------------
// tb_pagerank_apply
// Directed, table-driven bench. Two instances share one stimulus stream: the
// main one with MAX_ITER=64 and a second with MAX_ITER=2 to exercise the
// iteration cap. Each table row describes one iteration stream and the
// expected status/ranks once it completes.
// -----------------------------------------------------------------------------
module tb_pagerank_apply;
  import pagerank_pkg::*;

  localparam int unsigned N     = 32;
  localparam rank_t       BASE  = 64'd20132659;
  localparam rank_t       ONE_Q = 64'h0000_0001_0000_0000;
  localparam rank_t       HOT1  = 64'd3670854861;                 // BASE + d*1.0
  localparam rank_t       SATR  = (64'd3650722202 << 32) - 64'd1 + BASE; // BASE + floor((2^64-1)*d/2^32)
  localparam rank_t       ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock;
  logic reset_n;
  rank_t [N-1:0] payload;
  logic in_valid, stream_start, stream_done;

  pagerank_apply_if #(.NODES(N)) bus1 ();
  pagerank_apply_if #(.NODES(N)) bus2 ();

  assign bus1.pagerank_serial_stream = payload;
  assign bus1.in_valid               = in_valid;
  assign bus1.stream_start           = stream_start;
  assign bus1.stream_done            = stream_done;
  assign bus2.pagerank_serial_stream = payload;
  assign bus2.in_valid               = in_valid;
  assign bus2.stream_start           = stream_start;
  assign bus2.stream_done            = stream_done;

  pagerank_apply #(
    .NUM_HW_THREADS(8), .NODES_IN_GRAPH(N), .DAMPING_Q(32'd3650722202),
    .EPS_Q(64'd4295), .MAX_ITER(64)
  ) dut (.clock(clock), .reset_n(reset_n), .bus(bus1));

  pagerank_apply #(
    .NUM_HW_THREADS(8), .NODES_IN_GRAPH(N), .DAMPING_Q(32'd3650722202),
    .EPS_Q(64'd4295), .MAX_ITER(2)
  ) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int    npk;        // packets sent
    int    hot_node;   // node carrying hot_val
    rank_t hot_val;
    int    hot_pkts;   // the last hot_pkts packets carry hot_val
    bit    done_last;  // stream_done coincides with the last packet
    rank_t exp_hot;
    rank_t exp_oth;
    bit    exp_pulse;
    bit    exp_conv;
    bit    exp_fin;
    int    exp_iter;
    bit    exp_err;
    bit    d2_pulse;
    bit    d2_fin;
  } row_t;

  row_t rows [6];
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_row(input int r);
    row_t v;
    int   cnt;
    bit   seen;
    bit   last_done;
    v = rows[r];
    @(negedge clock);
    stream_start = 1'b1;
    @(negedge clock);
    stream_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < v.npk; k++) begin
      last_done = v.done_last && (k == v.npk - 1);
      payload = '0;
      if (k >= v.npk - v.hot_pkts) payload[v.hot_node] = v.hot_val;
      in_valid = 1'b1;
      if (last_done) stream_done = 1'b1;
      @(posedge clock);
      #1;
      chk($sformatf("row%0d ack_hi pkt%0d", r, k), bus1.ack, 1);
      @(negedge clock);
      in_valid    = 1'b0;
      stream_done = 1'b0;
      payload     = '0;
      if (last_done) begin
        cnt = 1;
      end else begin
        @(posedge clock);
        #1;
        chk($sformatf("row%0d ack_lo pkt%0d", r, k), bus1.ack, 0);
        @(negedge clock);
      end
    end
    if (!v.done_last) begin
      stream_done = 1'b1;
      @(posedge clock);
      cnt = 1;
      @(negedge clock);
      stream_done = 1'b0;
    end
    seen = 1'b0;
    while (!seen && cnt < 60) begin
      @(posedge clock);
      #1;
      cnt++;
      if (bus1.rank_valid) seen = 1'b1;
    end
    chk($sformatf("row%0d latency", r), cnt, 33);
    chk($sformatf("row%0d next_iteration", r), bus1.next_iteration, v.exp_pulse);
    chk($sformatf("row%0d converged", r), bus1.converged, v.exp_conv);
    chk($sformatf("row%0d finished", r), bus1.finished, v.exp_fin);
    chk($sformatf("row%0d iter_count", r), bus1.iter_count, v.exp_iter);
    chk($sformatf("row%0d pkt_error", r), bus1.pkt_error, v.exp_err);
    chk($sformatf("row%0d cap next_iteration", r), bus2.next_iteration, v.d2_pulse);
    chk($sformatf("row%0d cap finished", r), bus2.finished, v.d2_fin);
    for (int n = 0; n < N; n++) begin
      chk($sformatf("row%0d rank_out[%0d]", r, n), bus1.rank_out[n],
          (n == v.hot_node) ? v.exp_hot : v.exp_oth);
    end
    @(posedge clock);
    #1;
    chk($sformatf("row%0d pulse_end", r), bus1.next_iteration, 0);
    chk($sformatf("row%0d rank_valid_hold", r), bus1.rank_valid, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " ack"}, bus1.ack, 0);
    chk({tag, " rank_valid"}, bus1.rank_valid, 0);
    chk({tag, " next_iteration"}, bus1.next_iteration, 0);
    chk({tag, " converged"}, bus1.converged, 0);
    chk({tag, " finished"}, bus1.finished, 0);
    chk({tag, " iter_count"}, bus1.iter_count, 0);
    chk({tag, " pkt_error"}, bus1.pkt_error, 0);
    chk({tag, " rank_out"}, {63'd0, |bus1.rank_out}, 0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    payload      = '0;
    in_valid     = 1'b0;
    stream_start = 1'b0;
    stream_done  = 1'b0;
    reset_n      = 1'b1;

    //          npk node val   hp dl  exp_hot exp_oth  pls cnv fin it err d2p d2f
    rows[0] = '{8, 0, 64'd0, 0, 1'b0, BASE, BASE, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    rows[1] = '{8, 0, ONE_Q, 1, 1'b0, HOT1, BASE, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    rows[2] = '{8, 0, ONE_Q, 1, 1'b0, HOT1, BASE, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1};
    rows[3] = '{8, 3, ALL1,  2, 1'b0, SATR, BASE, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    rows[4] = '{8, 5, ONE_Q, 1, 1'b1, HOT1, BASE, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1};
    rows[5] = '{7, 5, 64'd0, 0, 1'b0, BASE, BASE, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1};

    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int r = 0; r < 6; r++) begin
      if (r == 3) begin
        // Once finished, a new stream_start must not start an iteration.
        @(negedge clock);
        stream_start = 1'b1;
        repeat (2) @(negedge clock);
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        chk("ignore ack", bus1.ack, 0);
        @(negedge clock);
        in_valid    = 1'b0;
        stream_done = 1'b1;
        @(negedge clock);
        stream_done = 1'b0;
        begin
          bit saw_next;
          saw_next = 1'b0;
          repeat (40) begin
            @(posedge clock);
            #1;
            if (bus1.next_iteration || !bus1.rank_valid) saw_next = 1'b1;
          end
          chk("ignore activity", saw_next, 0);
        end
        chk("ignore iter_count", bus1.iter_count, 3);
        stream_start = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
      end
      run_row(r);
    end

    // Reset in the middle of APPLY, at node index 10.
    @(negedge clock);
    stream_start = 1'b1;
    @(negedge clock);
    stream_start = 1'b0;
    in_valid     = 1'b1;
    repeat (8) @(negedge clock);
    in_valid    = 1'b0;
    stream_done = 1'b1;
    @(posedge clock);
    @(negedge clock);
    stream_done = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midapply");
    @(negedge clock);
    reset_n = 1'b1;
    run_row(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
